caster_rx_fifo: RTL
===================

CASTER_RX_FIFO -- requirements
Module: caster_rx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of one multicast data word.
REQ-002 Parameter NUM_COL, default 4: number of PE columns; TW = $clog2(NUM_COL) is the ID/TAG width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 id_wr  input  1  load column ID this cycle.
REQ-006 id_in  input  TW  column ID value to load.
REQ-007 bus_valid  input  1  bus word and tag valid.
REQ-008 bus_tag  input  TW  destination column tag of bus word.
REQ-009 bus_data  input  DATA_WIDTH  bus word.
REQ-010 caster_ready  output  1  this caster accepts (or releases) the current bus word.
REQ-011 pe_valid  output  1  head word available to PE.
REQ-012 pe_data  output  DATA_WIDTH  head word.
REQ-013 pe_ready  input  1  PE consumes head word this cycle.
REQ-014 configured  output  1  column ID loaded.
REQ-015 deliv_cnt  output  16  delivered-word count (see Configuration).

Function
REQ-016 Two-entry FIFO of DATA_WIDTH words; state machine UNCONF, EMPTY, ONE, FULL.
REQ-017 UNCONF: caster_ready=0, pe_valid=0, configured=0; id_wr=1 -> latch id_in, go EMPTY.
REQ-018 id_wr in EMPTY reloads ID; id_wr in ONE/FULL ignored (ID and state unchanged).
REQ-019 match = bus_tag == stored ID; caster_ready = configured & (!match | state != FULL).
REQ-020 Bus transfer occurs when bus_valid & caster_ready; push occurs only on transfer with match; non-matching transfers are dropped silently.
REQ-021 caster_ready is combinational from bus_tag and state; it does not depend on pe_ready (no full-state bypass).
REQ-022 pop occurs when pe_valid & pe_ready; pe_valid = state in {ONE, FULL}; pe_data = head entry, registered storage, no combinational path from bus_data.
REQ-023 Latency: word pushed at edge N is visible on pe_valid/pe_data after edge N (cycle N+1) when FIFO was empty.
REQ-024 Transitions: EMPTY push->ONE; ONE push only->FULL; ONE pop only->EMPTY; ONE push+pop->ONE with new word at head next cycle; FULL pop->ONE; FULL push impossible.
REQ-025 Order preserved: words reach PE in bus-transfer order.
REQ-026 pe_data holds its value while pe_valid=1 and pe_ready=0.

Reset
REQ-027 rst_n=0 at an edge: state UNCONF, stored ID 0, FIFO contents discarded, deliv_cnt 0.
REQ-028 Reset values: caster_ready=0, pe_valid=0, pe_data=0, configured=0, deliv_cnt=0.
REQ-029 Reset mid-transfer discards any in-flight word; ID must be reloaded after reset.

Configuration
REQ-030 Macro CASTER_DELIV_CNT_EN defined: deliv_cnt increments by 1 on every pop, wraps 0xFFFF->0x0000, cleared by reset and by any accepted id_wr.
REQ-031 Macro CASTER_DELIV_CNT_EN undefined: deliv_cnt tied to 0, no counter flops.

Verification
REQ-032 Reset, no id_wr, bus_valid=1 tag=2 -> caster_ready=0, pe_valid=0 indefinitely.
REQ-033 Load ID=2; bus word 0x1234 tag=2, pe_ready=1 -> pe_valid=1 pe_data=0x1234 next cycle, deliv_cnt=1 after pop.
REQ-034 ID=2, pe_ready=0; words 0xA, 0xB tag=2 then 0xC tag=2 -> caster_ready=0 at 0xC; 0xC tag=1 -> caster_ready=1, dropped; release pe_ready -> outputs 0xA then 0xB.
REQ-035 ID=1, ONE state, simultaneous push 0x55 and pop -> state ONE, pe_data=0x55 next cycle.
REQ-036 FULL state, assert rst_n=0 one cycle -> pe_valid=0, configured=0, deliv_cnt=0; id_wr in FULL before reset leaves ID unchanged.
REQ-037 With CASTER_DELIV_CNT_EN, 65537 pops -> deliv_cnt=1; without macro deliv_cnt=0 throughout.

Source files
------------

// File: rtl/caster_rx_fifo.sv
// rtl/caster_rx_fifo.sv - per-column two-entry receive FIFO for a tagged multicast bus
// Optional delivered-word counter enabled by defining CASTER_DELIV_CNT_EN.
module caster_rx_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  localparam int TW        = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_wr,
  input  logic [TW-1:0]         id_in,
  input  logic                  bus_valid,
  input  logic [TW-1:0]         bus_tag,
  input  logic [DATA_WIDTH-1:0] bus_data,
  output logic                  caster_ready,
  output logic                  pe_valid,
  output logic [DATA_WIDTH-1:0] pe_data,
  input  logic                  pe_ready,
  output logic                  configured,
  output logic [15:0]           deliv_cnt
);

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    EMPTY  = 2'd1,
    ONE    = 2'd2,
    FULL   = 2'd3
  } state_t;

  state_t                state_q;
  logic [TW-1:0]         id_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic                  pe_valid_q;
  logic                  configured_q;

  logic match;
  logic push;
  logic pop;
  logic id_accept;

  // A non-matching word is always released so the bus never stalls on other columns' traffic.
  assign match        = (bus_tag == id_q);
  assign caster_ready = configured_q & (~match | (state_q != FULL));
  assign push         = bus_valid & caster_ready & match;
  assign pop          = pe_valid_q & pe_ready;
  assign id_accept    = id_wr & ((state_q == UNCONF) | (state_q == EMPTY));

  assign pe_valid   = pe_valid_q;
  assign pe_data    = head_q;
  assign configured = configured_q;

  // Occupancy FSM: head_q is always the word presented to the PE, tail_q the one queued behind it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= UNCONF;
      id_q         <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      pe_valid_q   <= 1'b0;
      configured_q <= 1'b0;
    end else begin
      case (state_q)
        UNCONF: begin
          if (id_wr) begin
            id_q         <= id_in;
            configured_q <= 1'b1;
            state_q      <= EMPTY;
          end
        end
        EMPTY: begin
          if (id_wr) begin
            id_q <= id_in;
          end
          if (push) begin
            head_q     <= bus_data;
            pe_valid_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              tail_q  <= bus_data;
              state_q <= FULL;
            end
            2'b01: begin
              pe_valid_q <= 1'b0;
              state_q    <= EMPTY;
            end
            2'b11: begin
              head_q <= bus_data;
            end
            default: begin
            end
          endcase
        end
        FULL: begin
          if (pop) begin
            head_q  <= tail_q;
            state_q <= ONE;
          end
        end
        default: begin
          state_q <= UNCONF;
        end
      endcase
    end
  end

`ifdef CASTER_DELIV_CNT_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (id_accept) begin
      cnt_d = 16'd0;
    end else if (pop) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Delivered-word counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign deliv_cnt = cnt_q;
`else
  logic unused_id_accept;
  assign unused_id_accept = id_accept;
  assign deliv_cnt        = 16'd0;
`endif

endmodule
